// File: rtl/immediate_gen_pipe_if.sv
// rtl/immediate_gen_pipe_if.sv - request/result bundle for the immediate generator pipe
//
// Purpose: groups the request handshake (in_*) and result handshake (out_*)
// of immediate_gen_pipe into one interface.
// Ports (signals):
//   in_valid/in_ready   request handshake
//   instruction[31:0]   raw instruction word
//   select[3:0]         [2:0] format code, [3] 1 = zero-extend, 0 = sign-extend
//   in_tag[TAG_W-1:0]   sideband tag carried with the request
//   out_valid/out_ready result handshake (head of FIFO)
//   out_imm[XLEN-1:0]   head immediate
//   out_tag[TAG_W-1:0]  head tag
//   out_err             head entry had an unsupported format
// Modports: master = producer/consumer side, slave = the generator.

interface immediate_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instruction;
    logic [3:0]       select;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, instruction, select, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport slave (
        input  in_valid, instruction, select, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );
endinterface

// File: rtl/immediate_gen_pipe.sv
// rtl/immediate_gen_pipe.sv - RISC-V style immediate decoder feeding a result FIFO
//
// Purpose: decodes the immediate field of an accepted instruction according to
// select[2:0] (U/J/I/B/S, optional shift amount), extends it to XLEN, and
// queues {imm, tag, err} in a DEPTH-entry FIFO drained in acceptance order.
// Parameters: XLEN (32 or 64), DEPTH (2..8), TAG_W.
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-high; clears count, pointers and storage
//   flush  synchronous discard of all buffered entries (beats push and pop)
//   bus    immediate_gen_pipe_if.slave (request and result handshakes)
// Configuration macro: IMM_SHAMT_EN -- when defined, format code 101 decodes a
// shift amount (I[24:20] for XLEN=32, I[25:20] for XLEN=64); otherwise code
// 101 is reported as unsupported.

module immediate_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    immediate_gen_pipe_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // Decode. Every format's field MSB is I[31], so one extension bit
    // serves all of them. Decoding is done at 64 bits and truncated.
    // ------------------------------------------------------------------
    logic [63:0]     ext64;
    logic            dec_err;
    logic            sx;
    logic [XLEN-1:0] dec_imm;

    assign sx = ~bus.select[3] & bus.instruction[31];

    always_comb begin
        ext64   = '0;
        dec_err = 1'b0;
        case (bus.select[2:0])
            3'b000: ext64 = {{32{sx}}, bus.instruction[31:12], 12'b0};
            3'b001: ext64 = {{43{sx}}, bus.instruction[31], bus.instruction[19:12],
                             bus.instruction[20], bus.instruction[30:21], 1'b0};
            3'b010: ext64 = {{52{sx}}, bus.instruction[31:20]};
            3'b011: ext64 = {{51{sx}}, bus.instruction[31], bus.instruction[7],
                             bus.instruction[30:25], bus.instruction[11:8], 1'b0};
            3'b100: ext64 = {{52{sx}}, bus.instruction[31:25], bus.instruction[11:7]};
`ifdef IMM_SHAMT_EN
            // Shift amount is always zero-extended; select[3] is ignored.
            3'b101: ext64 = (XLEN == 64) ? {58'b0, bus.instruction[25:20]}
                                         : {59'b0, bus.instruction[24:20]};
`endif
            default: begin
                ext64   = '0;
                dec_err = 1'b1;
            end
        endcase
    end

    assign dec_imm = ext64[XLEN-1:0];

    // Opcode bits never feed an immediate; upper decode bits idle when XLEN=32.
    logic unused_bits;
    assign unused_bits = ^{bus.instruction[6:0], ext64};

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  imm_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [DEPTH-1:0] err_mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // in_ready depends only on count, never on out_ready.
    assign bus.in_ready  = (count < FULL_CNT);
    assign bus.out_valid = (count != '0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    assign bus.out_imm = bus.out_valid ? imm_mem[rd_ptr] : '0;
    assign bus.out_tag = bus.out_valid ? tag_mem[rd_ptr] : '0;
    assign bus.out_err = bus.out_valid ? err_mem[rd_ptr] : 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_mem <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                imm_mem[i] <= '0;
                tag_mem[i] <= '0;
            end
        end else if (flush) begin
            // Any request presented in this cycle is dropped.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                imm_mem[wr_ptr] <= dec_imm;
                tag_mem[wr_ptr] <= bus.in_tag;
                err_mem[wr_ptr] <= dec_err;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_immediate_gen_pipe.sv
// tb/tb_immediate_gen_pipe.sv - self-checking bench for immediate_gen_pipe

module tb_immediate_gen_pipe;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    always #5 clk = ~clk;

    immediate_gen_pipe_if #(.XLEN(32), .TAG_W(5)) if32 ();
    immediate_gen_pipe_if #(.XLEN(64), .TAG_W(5)) if64 ();

    immediate_gen_pipe #(.XLEN(32), .DEPTH(4), .TAG_W(5)) dut32 (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (if32)
    );

    immediate_gen_pipe #(.XLEN(64), .DEPTH(4), .TAG_W(5)) dut64 (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (if64)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: field value and width from the format rules, then
    // two's-complement arithmetic for sign extension and masking to XLEN.
    function automatic logic [63:0] model_imm(input logic [31:0] ins, input logic [3:0] sel,
                                              input int xlen, output logic err);
        longint unsigned raw;
        int w;
        err = 1'b0;
        raw = 0;
        w   = 1;
        case (sel[2:0])
            3'd0: begin raw = 64'(ins[31:12]) << 12; w = 32; end
            3'd1: begin
                raw = (64'(ins[31]) << 20) + (64'(ins[19:12]) << 12)
                    + (64'(ins[20]) << 11) + (64'(ins[30:21]) << 1);
                w = 21;
            end
            3'd2: begin raw = 64'(ins[31:20]); w = 12; end
            3'd3: begin
                raw = (64'(ins[31]) << 12) + (64'(ins[7]) << 11)
                    + (64'(ins[30:25]) << 5) + (64'(ins[11:8]) << 1);
                w = 13;
            end
            3'd4: begin raw = (64'(ins[31:25]) << 5) + 64'(ins[11:7]); w = 12; end
`ifdef IMM_SHAMT_EN
            3'd5: return (xlen == 32) ? 64'(ins[24:20]) : 64'(ins[25:20]);
`endif
            default: begin err = 1'b1; return 64'd0; end
        endcase
        if (!sel[3] && raw[w-1]) raw = raw - (64'd1 << w);
        if (xlen == 32) raw = raw & 64'hFFFF_FFFF;
        return raw;
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  sel;
        logic [31:0] exp32;
        logic [63:0] exp64;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] imm;
        logic [4:0]  tag;
        logic        err;
    } ent_t;

    vec_t vecs[$];
    ent_t model_q[$];
    int   got_tags[$];

    task automatic set_req(input logic [31:0] ins, input logic [3:0] sel, input logic [4:0] tag);
        if32.instruction = ins;
        if32.select      = sel;
        if32.in_tag      = tag;
        if64.instruction = ins;
        if64.select      = sel;
        if64.in_tag      = tag;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic        err_m;
        logic [63:0] m_imm;
        logic [39:0] exp_bus;
        logic        do_push, do_pop, do_flush, rdy;
        int          acc;
        ent_t        e;

        vecs.push_back('{32'hFFF00093, 4'b0010, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0});
        vecs.push_back('{32'hFFF00093, 4'b1010, 32'h00000FFF, 64'h0000000000000FFF, 1'b0});
        vecs.push_back('{32'h12345037, 4'b0000, 32'h12345000, 64'h0000000012345000, 1'b0});
        vecs.push_back('{32'hFE000EE3, 4'b0011, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0});
        vecs.push_back('{32'h800000EF, 4'b0001, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0});
        vecs.push_back('{32'h800000EF, 4'b1001, 32'h00100000, 64'h0000000000100000, 1'b0});
        vecs.push_back('{32'h80000080, 4'b0100, 32'hFFFFF801, 64'hFFFFFFFFFFFFF801, 1'b0});
        vecs.push_back('{32'h80000080, 4'b1100, 32'h00000801, 64'h0000000000000801, 1'b0});
        vecs.push_back('{32'h80000037, 4'b0000, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0});
        vecs.push_back('{32'h80000037, 4'b1000, 32'h80000000, 64'h0000000080000000, 1'b0});
`ifdef IMM_SHAMT_EN
        vecs.push_back('{32'h00F09093, 4'b0101, 32'h0000000F, 64'h000000000000000F, 1'b0});
        vecs.push_back('{32'h03F01093, 4'b1101, 32'h0000001F, 64'h000000000000003F, 1'b0});
`else
        vecs.push_back('{32'h00F09093, 4'b0101, 32'h00000000, 64'h0000000000000000, 1'b1});
        vecs.push_back('{32'h03F01093, 4'b1101, 32'h00000000, 64'h0000000000000000, 1'b1});
`endif
        vecs.push_back('{32'h00F09093, 4'b0110, 32'h00000000, 64'h0000000000000000, 1'b1});
        vecs.push_back('{32'hFFFFFFFF, 4'b1111, 32'h00000000, 64'h0000000000000000, 1'b1});

        // Reset state, checked before the first clock edge.
        reset = 1'b1;
        flush = 1'b0;
        if32.in_valid = 1'b0; if32.out_ready = 1'b0;
        if64.in_valid = 1'b0; if64.out_ready = 1'b0;
        set_req(32'h0, 4'h0, 5'h0);
        #2;
        check("reset32", {if32.in_ready, if32.out_valid, if32.out_imm, if32.out_tag, if32.out_err},
              {1'b1, 1'b0, 32'h0, 5'h0, 1'b0});
        check("reset64", {if64.in_ready, if64.out_valid, if64.out_imm, if64.out_tag, if64.out_err},
              {1'b1, 1'b0, 64'h0, 5'h0, 1'b0});
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Table vectors on both widths; one entry in flight at a time.
        foreach (vecs[i]) begin
            if32.out_ready = 1'b1; if64.out_ready = 1'b1;
            if32.in_valid  = 1'b1; if64.in_valid  = 1'b1;
            set_req(vecs[i].instr, vecs[i].sel, 5'(i));
            @(negedge clk);
            if32.in_valid = 1'b0; if64.in_valid = 1'b0;
            check($sformatf("vec32[%0d]", i),
                  {if32.out_valid, if32.out_imm, if32.out_tag, if32.out_err},
                  {1'b1, vecs[i].exp32, 5'(i), vecs[i].exp_err});
            check($sformatf("vec64[%0d]", i),
                  {if64.out_valid, if64.out_imm, if64.out_tag, if64.out_err},
                  {1'b1, vecs[i].exp64, 5'(i), vecs[i].exp_err});
            @(negedge clk);
        end
        if64.out_ready = 1'b0;

        // Randomized traffic against the queue model, with occasional flush.
        model_q.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (model_q.size() > 0)
                exp_bus = {model_q.size() < 4, 1'b1, model_q[0].imm, model_q[0].tag, model_q[0].err};
            else
                exp_bus = {1'b1, 1'b0, 32'h0, 5'h0, 1'b0};
            check($sformatf("random cyc %0d", c),
                  {if32.in_ready, if32.out_valid, if32.out_imm, if32.out_tag, if32.out_err}, exp_bus);
            do_flush       = ($urandom_range(0, 39) == 0);
            flush          = do_flush;
            if32.in_valid  = ($urandom_range(0, 3) != 0);
            if32.out_ready = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            if32.instruction = $urandom;
            if32.select      = 4'($urandom_range(0, 15));
            if32.in_tag      = 5'($urandom_range(0, 31));
            do_push = if32.in_valid && (model_q.size() < 4);
            do_pop  = if32.out_ready && (model_q.size() > 0);
            m_imm   = model_imm(if32.instruction, if32.select, 32, err_m);
            e.imm = m_imm[31:0]; e.tag = if32.in_tag; e.err = err_m;
            @(posedge clk);
            if (do_flush) model_q.delete();
            else begin
                if (do_pop)  void'(model_q.pop_front());
                if (do_push) model_q.push_back(e);
            end
        end
        @(negedge clk);
        flush = 1'b1; if32.in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;

        // Fill with the consumer stalled: five requests held back-to-back.
        if32.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            if32.in_valid = 1'b1;
            if32.instruction = 32'hFFF00093;
            if32.select      = 4'b0010;
            if32.in_tag      = 5'(acc);
            rdy = if32.in_ready;
            @(posedge clk);
            if (rdy) acc++;
            @(negedge clk);
        end
        check("fill accepts", 32'(acc), 32'd4);
        check("fill in_ready low", if32.in_ready, 1'b0);

        // Drain: tags 0..3 then the held 5th request.
        if32.out_ready = 1'b1;
        got_tags.delete();
        for (int c = 0; c < 16 && got_tags.size() < 5; c++) begin
            if (c == 0) check("full ready low", if32.in_ready, 1'b0);
            if (c == 1) check("ready after pop", if32.in_ready, 1'b1);
            if (if32.out_valid) got_tags.push_back(int'(if32.out_tag));
            rdy = if32.in_ready && if32.in_valid;
            if (rdy) if32.in_tag = 5'(acc);
            @(posedge clk);
            @(negedge clk);
            if (rdy) if32.in_valid = 1'b0;
        end
        check("drain count", 32'(got_tags.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("drain order %0d", i),
                  (i < got_tags.size()) ? 32'(got_tags[i]) : 32'hFFFF_FFFF, 32'(i));
        if32.out_ready = 1'b0;
        @(negedge clk);

        // Flush with a request presented: everything dropped.
        for (int i = 0; i < 3; i++) begin
            if32.in_valid = 1'b1; if32.in_tag = 5'(i);
            @(negedge clk);
        end
        check("pre-flush valid", if32.out_valid, 1'b1);
        flush = 1'b1; if32.in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; if32.in_valid = 1'b0;
        check("flush empty", {if32.out_valid, if32.in_ready, if32.out_imm, if32.out_tag},
              {1'b0, 1'b1, 32'h0, 5'h0});
        @(negedge clk);
        check("flush dropped req", if32.out_valid, 1'b0);

        // Reset asserted mid-cycle with entries buffered.
        for (int i = 0; i < 3; i++) begin
            if32.in_valid = 1'b1; if32.in_tag = 5'(i + 3);
            @(negedge clk);
        end
        if32.in_valid = 1'b0;
        check("pre-reset valid", if32.out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async reset", {if32.in_ready, if32.out_valid, if32.out_imm, if32.out_tag, if32.out_err},
              {1'b1, 1'b0, 32'h0, 5'h0, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        if32.in_valid = 1'b1;
        set_req(32'hFFF00093, 4'b0010, 5'd9);
        @(negedge clk);
        if32.in_valid = 1'b0;
        check("post-reset push", {if32.out_valid, if32.out_imm, if32.out_tag, if32.out_err},
              {1'b1, 32'hFFFFFFFF, 5'd9, 1'b0});
        if32.out_ready = 1'b1;
        @(negedge clk);
        check("post-reset single", if32.out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
